// File: rtl/rsa_modexp_seq.sv
// rsa_modexp_seq: sequencer between a host stream and the word-serial Montgomery modexp engine.
// Latency: host triplet -> eng_wr/eng_n/m/e 1 cycle; result word every 3 cycles (READ, capture, accept).
// Backpressure: in_ready only in LOAD; a held result word (out_valid & !out_ready) stalls further engine reads.
//
// Ports:
//   clk, reset (async, active-low)    : clock and reset
//   start / busy / done / error       : job control and status (error sticky, timeout build only)
//   in_valid / in_ready / in_n,m,e    : host operand stream, LS word first
//   eng_start / eng_wr / eng_n,m,e    : engine load interface (registered words)
//   eng_done / eng_get_result / eng_res : engine completion and result read-out
//   out_valid / out_ready / out_data / out_last : host result stream, LS word first
//
// Optional build macro RSA_SEQ_TIMEOUT_EN: adds a COMPUTE watchdog of TIMEOUT_CYCLES cycles
// that raises error and abandons the job. Without it error is tied low and COMPUTE waits forever.

module rsa_modexp_seq #(
  parameter int WORD_W         = 32,
  parameter int NUM_WORDS      = 32,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              error,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_n,
  input  logic [WORD_W-1:0] in_m,
  input  logic [WORD_W-1:0] in_e,
  output logic              eng_start,
  output logic              eng_wr,
  output logic [WORD_W-1:0] eng_n,
  output logic [WORD_W-1:0] eng_m,
  output logic [WORD_W-1:0] eng_e,
  input  logic              eng_done,
  output logic              eng_get_result,
  input  logic [WORD_W-1:0] eng_res,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic              out_last
);

  localparam int               CNT_W    = $clog2(NUM_WORDS);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_WORDS - 1);

  typedef enum logic [2:0] {IDLE, LOAD, COMPUTE, READ, HOLD} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] load_cnt, rd_cnt;
  logic             capture;      // eng_res is valid this cycle (cycle after eng_get_result)
  logic             in_xfer, out_xfer, start_acc;
  logic             eng_done_ok;  // completion that is not masked by the final load strobe
  logic             timeout;

  assign in_xfer     = in_valid & in_ready;
  assign out_xfer    = out_valid & out_ready;
  assign start_acc   = (state == IDLE) & start;
  // The engine cannot have finished in the cycle it receives its final word.
  assign eng_done_ok = eng_done & ~eng_wr;
  assign out_last    = out_valid & (rd_cnt == LAST_IDX);

  always_comb begin
    state_nxt      = state;
    busy           = 1'b1;
    in_ready       = 1'b0;
    eng_start      = 1'b0;
    eng_get_result = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = LOAD;
      end
      LOAD: begin
        in_ready  = 1'b1;
        eng_start = 1'b1;
        if (in_valid && (load_cnt == LAST_IDX)) state_nxt = COMPUTE;
      end
      COMPUTE: begin
        // eng_start stays high through the final registered load strobe.
        eng_start = eng_wr;
        if (eng_done_ok)  state_nxt = READ;
        else if (timeout) state_nxt = IDLE;
      end
      READ: begin
        eng_get_result = 1'b1;
        state_nxt      = HOLD;
      end
      HOLD: begin
        if (out_valid && out_ready) state_nxt = (rd_cnt == LAST_IDX) ? IDLE : READ;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      load_cnt  <= '0;
      rd_cnt    <= '0;
      eng_wr    <= 1'b0;
      eng_n     <= '0;
      eng_m     <= '0;
      eng_e     <= '0;
      capture   <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      done      <= 1'b0;
    end else begin
      state   <= state_nxt;
      eng_wr  <= in_xfer;
      capture <= (state == READ);
      done    <= (state == HOLD) & out_xfer & (rd_cnt == LAST_IDX);

      if (in_xfer) begin
        eng_n <= in_n;
        eng_m <= in_m;
        eng_e <= in_e;
      end

      // Counters saturate at the last index; the state exits happen there.
      if (start_acc) begin
        load_cnt <= '0;
        rd_cnt   <= '0;
      end else begin
        if (in_xfer && (load_cnt != LAST_IDX)) load_cnt <= load_cnt + 1'b1;
        if (out_xfer && (rd_cnt != LAST_IDX))  rd_cnt   <= rd_cnt + 1'b1;
      end

      if (capture) begin
        out_data  <= eng_res;
        out_valid <= 1'b1;
      end else if (out_xfer) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef RSA_SEQ_TIMEOUT_EN
  localparam int               TMO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [TMO_W-1:0] tmo_cnt;

  // Fires in the TIMEOUT_CYCLES-th COMPUTE cycle unless the engine finishes in that same cycle.
  assign timeout = (state == COMPUTE) & (tmo_cnt == TMO_LAST) & ~eng_done_ok;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmo_cnt <= '0;
      error   <= 1'b0;
    end else begin
      tmo_cnt <= (state == COMPUTE) ? tmo_cnt + 1'b1 : '0;
      if (start_acc)    error <= 1'b0;
      else if (timeout) error <= 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
  assign error   = 1'b0;
`endif

endmodule

// File: tb/tb_rsa_modexp_seq.sv
// tb_rsa_modexp_seq: directed + randomized check of rsa_modexp_seq with NUM_WORDS=4.
// A negedge monitor logs engine writes, result reads and host output transfers; the
// main sequence compares them against the operand/result lists it generated itself.

`define CHK(t, o, e) chk(t, 160'(o), 160'(e))

module tb_rsa_modexp_seq;
  localparam int WORD_W         = 32;
  localparam int NUM_WORDS      = 4;
  localparam int TIMEOUT_CYCLES = 100;

  localparam logic [31:0] FN [NUM_WORDS] = '{32'h8E12B6DB, 32'hDBF291EB, 32'h99A93151, 32'hD5E10615};
  localparam logic [31:0] FM [NUM_WORDS] = '{32'h08403477, 32'h675152D8, 32'h30B302A4, 32'h0A76E56A};
  localparam logic [31:0] FE [NUM_WORDS] = '{32'h89F79C82, 32'h17AF118B, 32'h84F66C41, 32'hB77CC5A6};
  localparam logic [31:0] FR [NUM_WORDS] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};

  logic clk = 1'b0, reset = 1'b0, start = 1'b0, in_valid = 1'b0, eng_done = 1'b0, out_ready = 1'b0;
  logic [WORD_W-1:0] in_n = '0, in_m = '0, in_e = '0, eng_res = '0;
  logic busy, done, error, in_ready, eng_start, eng_wr, eng_get_result, out_valid, out_last;
  logic [WORD_W-1:0] eng_n, eng_m, eng_e, out_data;

  rsa_modexp_seq #(.WORD_W(WORD_W), .NUM_WORDS(NUM_WORDS), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done), .error(error),
    .in_valid(in_valid), .in_ready(in_ready), .in_n(in_n), .in_m(in_m), .in_e(in_e),
    .eng_start(eng_start), .eng_wr(eng_wr), .eng_n(eng_n), .eng_m(eng_m), .eng_e(eng_e),
    .eng_done(eng_done), .eng_get_result(eng_get_result), .eng_res(eng_res),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
  );

  always #5 clk = ~clk;

  int n_assert = 0, n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  typedef struct { logic [WORD_W-1:0] n, m, e; int c; } wr_t;
  wr_t               wr_q[$];
  logic [WORD_W:0]   out_q[$];   // {last, data}
  logic [WORD_W-1:0] res_mem[$]; // engine result words, consumed in order
  int res_idx = 0, gr_cnt = 0, done_cnt = 0;
  int viol_gr_valid = 0, viol_hold = 0, viol_done_busy = 0, viol_wr_start = 0;
  int good_fall = 0, bad_fall = 0;
  logic prev_start = 1'b0, prev_wr = 1'b0, prev_hold = 1'b0;
  logic [WORD_W-1:0] prev_data = '0;

  // Monitor + engine model (engine answers each read strobe with the next result word).
  always @(negedge clk) begin
    if (!reset) begin
      prev_start = 1'b0; prev_wr = 1'b0; prev_hold = 1'b0;
    end else begin
      if (eng_wr) begin
        wr_q.push_back('{eng_n, eng_m, eng_e, cyc});
        if (!eng_start) viol_wr_start++;
      end
      if (prev_start && !eng_start) begin
        if (prev_wr) good_fall++; else bad_fall++;
      end
      if (eng_get_result) begin
        gr_cnt++;
        if (out_valid) viol_gr_valid++;
        if (res_idx < res_mem.size()) eng_res = res_mem[res_idx];
        else eng_res = 32'hDEADBEEF;
        res_idx++;
      end
      if (prev_hold && out_valid && (out_data !== prev_data)) viol_hold++;
      prev_hold = out_valid && !out_ready;
      prev_data = out_data;
      if (out_valid && out_ready) out_q.push_back({out_last, out_data});
      if (done) begin
        done_cnt++;
        if (busy) viol_done_busy++;
      end
      prev_start = eng_start;
      prev_wr    = eng_wr;
    end
  end

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_words(input logic [WORD_W-1:0] n_w[NUM_WORDS], input logic [WORD_W-1:0] m_w[NUM_WORDS],
                            input logic [WORD_W-1:0] e_w[NUM_WORDS], input int gaps[NUM_WORDS],
                            output int xc[NUM_WORDS]);
    for (int i = 0; i < NUM_WORDS; i++) begin
      // start pulses during LOAD gaps must be ignored
      in_valid = 1'b0;
      start    = 1'b1;
      repeat (gaps[i]) tick();
      start    = 1'b0;
      in_n = n_w[i]; in_m = m_w[i]; in_e = e_w[i];
      in_valid = 1'b1;
      `CHK("load_in_ready", in_ready, 1'b1);
      tick();
      xc[i]    = cyc;
      in_valid = 1'b0;
    end
  endtask

  // One complete job; every expectation comes from the locally generated word lists.
  task automatic run_job(input bit fixed, input bit stall, input bit early_done, input bit rnd_ready,
                         input int wait_cyc);
    logic [WORD_W-1:0] n_w[NUM_WORDS], m_w[NUM_WORDS], e_w[NUM_WORDS], r_w[NUM_WORDS];
    int xc[NUM_WORDS], gaps[NUM_WORDS];
    int wr0, out0, gr0, dn0, gf0, budget, stall_ctr;
    for (int i = 0; i < NUM_WORDS; i++) begin
      n_w[i]  = fixed ? FN[i] : $urandom;
      m_w[i]  = fixed ? FM[i] : $urandom;
      e_w[i]  = fixed ? FE[i] : $urandom;
      r_w[i]  = fixed ? FR[i] : $urandom;
      gaps[i] = fixed ? ((i == 1) ? 2 : 0) : int'($urandom_range(0, 2));
      res_mem.push_back(r_w[i]);
    end
    wr0 = wr_q.size(); out0 = out_q.size(); gr0 = gr_cnt; dn0 = done_cnt; gf0 = good_fall;

    start = 1'b1;
    tick();
    start = 1'b0;
    `CHK("start_busy", busy, 1'b1);
    `CHK("start_in_ready", in_ready, 1'b1);

    load_words(n_w, m_w, e_w, gaps, xc);
    // first COMPUTE cycle: final strobe overlaps eng_start
    `CHK("final_in_ready_drop", in_ready, 1'b0);
    `CHK("final_wr", eng_wr, 1'b1);
    `CHK("final_wr_start", eng_start, 1'b1);
    eng_done = early_done;
    tick();
    eng_done = 1'b0;
    `CHK("eng_start_fall", eng_start, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    repeat (wait_cyc) tick();
    `CHK("compute_no_read", gr_cnt - gr0, 0);
    `CHK("compute_busy", busy, 1'b1);
    `CHK("compute_error", error, 1'b0);
    eng_done = 1'b1;
    tick();
    eng_done = 1'b0;

    stall_ctr = 0;
    budget    = 0;
    while ((done_cnt == dn0) && (budget < 200)) begin
      if (stall && (out_q.size() - out0 == 1) && out_valid && (stall_ctr < 5)) begin
        out_ready = 1'b0;
        stall_ctr++;
        `CHK("stall_data", out_data, r_w[1]);
        `CHK("stall_no_read", gr_cnt - gr0, 2);
      end else if (rnd_ready) begin
        out_ready = 1'($urandom_range(0, 1));
      end else begin
        out_ready = 1'b1;
      end
      tick();
      budget++;
    end
    out_ready = 1'b0;
    `CHK("unload_bounded", budget < 200, 1'b1);
    if (!rnd_ready) `CHK("unload_cycles", budget, stall ? 18 : 13);
    tick();
    tick();
    `CHK("done_once", done_cnt - dn0, 1);
    `CHK("idle_busy", busy, 1'b0);
    `CHK("wr_count", wr_q.size() - wr0, NUM_WORDS);
    for (int i = 0; i < NUM_WORDS && (wr0 + i) < wr_q.size(); i++) begin
      `CHK("wr_n", wr_q[wr0+i].n, n_w[i]);
      `CHK("wr_m", wr_q[wr0+i].m, m_w[i]);
      `CHK("wr_e", wr_q[wr0+i].e, e_w[i]);
      `CHK("wr_latency", wr_q[wr0+i].c, xc[i]);
    end
    `CHK("get_result_count", gr_cnt - gr0, NUM_WORDS);
    `CHK("out_count", out_q.size() - out0, NUM_WORDS);
    for (int i = 0; i < NUM_WORDS && (out0 + i) < out_q.size(); i++)
      `CHK("out_word", out_q[out0+i], {(i == NUM_WORDS - 1), r_w[i]});
    `CHK("start_fall_once", good_fall - gf0, 1);
  endtask

  initial begin
    logic [WORD_W-1:0] n_w[NUM_WORDS], m_w[NUM_WORDS], e_w[NUM_WORDS];
    int gaps[NUM_WORDS], xc[NUM_WORDS];
    int dn0;

    reset = 1'b0;
    repeat (3) tick();
    `CHK("rst_busy", busy, 1'b0);
    `CHK("rst_in_ready", in_ready, 1'b0);
    `CHK("rst_out_valid", out_valid, 1'b0);
    `CHK("rst_eng_start", eng_start, 1'b0);
    `CHK("rst_error", error, 1'b0);
    `CHK("rst_done", done, 1'b0);
    reset = 1'b1;
    tick();
    `CHK("idle_in_ready", in_ready, 1'b0);

    run_job(1'b1, 1'b0, 1'b1, 1'b0, 0);
    run_job(1'b1, 1'b1, 1'b0, 1'b0, 3);

    // Reset in the middle of LOAD, after two words
    start = 1'b1;
    tick();
    start = 1'b0;
    dn0 = done_cnt;
    for (int i = 0; i < 2; i++) begin
      in_n = $urandom | 32'h1; in_m = $urandom | 32'h1; in_e = $urandom | 32'h1;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
    end
    reset = 1'b0;
    #1;
    `CHK("rst_mid_ctrl", {busy, done, error, in_ready, eng_start, eng_wr, eng_get_result, out_valid, out_last}, 9'h0);
    `CHK("rst_mid_words", {eng_n, eng_m, eng_e, out_data}, 128'h0);
    tick();
    reset = 1'b1;
    tick();
    `CHK("rst_mid_no_done", done_cnt - dn0, 0);
    run_job(1'b1, 1'b0, 1'b0, 1'b0, 1);

`ifdef RSA_SEQ_TIMEOUT_EN
    // Watchdog: engine never finishes
    begin
      int gr0, out0;
      gr0 = gr_cnt; out0 = out_q.size(); dn0 = done_cnt;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < NUM_WORDS; i++) begin
        n_w[i] = $urandom; m_w[i] = $urandom; e_w[i] = $urandom; gaps[i] = 0;
      end
      load_words(n_w, m_w, e_w, gaps, xc);
      repeat (TIMEOUT_CYCLES - 1) tick();
      `CHK("tmo_before_busy", busy, 1'b1);
      `CHK("tmo_before_error", error, 1'b0);
      tick();
      `CHK("tmo_error", error, 1'b1);
      `CHK("tmo_busy", busy, 1'b0);
      `CHK("tmo_out_valid", out_valid, 1'b0);
      eng_done = 1'b1;
      tick();
      eng_done = 1'b0;
      tick();
      tick();
      `CHK("tmo_late_done_busy", busy, 1'b0);
      `CHK("tmo_no_read", gr_cnt - gr0, 0);
      `CHK("tmo_no_out", out_q.size() - out0, 0);
      `CHK("tmo_no_done", done_cnt - dn0, 0);
      `CHK("tmo_sticky", error, 1'b1);
      start = 1'b1;
      tick();
      start = 1'b0;
      `CHK("tmo_clear", error, 1'b0);
      `CHK("tmo_restart_busy", busy, 1'b1);
      reset = 1'b0;
      tick();
      reset = 1'b1;
      tick();
    end
`else
    // No watchdog: a long COMPUTE wait must keep the job alive
    run_job(1'b1, 1'b0, 1'b0, 1'b0, 150);
`endif

    for (int j = 0; j < 6; j++)
      run_job(1'b0, (j % 2) == 1, (j % 3) == 0, 1'b1, int'($urandom_range(0, 20)));

    `CHK("no_read_while_valid", viol_gr_valid, 0);
    `CHK("hold_stable", viol_hold, 0);
    `CHK("done_not_busy", viol_done_busy, 0);
    `CHK("wr_under_start", viol_wr_start, 0);
    `CHK("start_fall_after_wr", bad_fall, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, observed no completion expected $finish");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/rsa_modexp_seq.md
Name: rsa_modexp_seq

Overview:
- Sequencer in front of the 32-bit word-serial Montgomery modular-exponentiation engine (RSA decryption).
- Accepts (n, m, e) word triplets from a host stream and loads them into the engine one word per strobe.
- Waits for the engine to finish, then unloads the result words to a host output stream with valid/ready flow control.
- One job in flight at a time.

Parameters:
- WORD_W, 32, width of every operand/result word.
- NUM_WORDS, 32, words per operand and per result; must be ≥2.
- TIMEOUT_CYCLES, 1048576, compute-phase watchdog limit (used only with the optional feature).

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low; 0 forces the reset state immediately.
- start  in  1  single-cycle job request; honoured only in IDLE.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the last result word is accepted.
- error  out  1  sticky timeout flag.
- in_valid  in  1  host triplet valid.
- in_ready  out  1  sequencer accepts a triplet.
- in_n  in  WORD_W  modulus word, LS word first.
- in_m  in  WORD_W  ciphertext word.
- in_e  in  WORD_W  private-exponent word.
- eng_start  out  1  level to engine startInput; high throughout LOAD.
- eng_wr  out  1  per-word load strobe to the engine.
- eng_n  out  WORD_W  registered word to the engine.
- eng_m  out  WORD_W  registered word to the engine.
- eng_e  out  WORD_W  registered word to the engine.
- eng_done  in  1  engine completion pulse/level.
- eng_get_result  out  1  one-cycle result-word read strobe to the engine.
- eng_res  in  WORD_W  engine result word, valid one cycle after eng_get_result.
- out_valid  out  1  result word valid.
- out_ready  in  1  host accepts the result word.
- out_data  out  WORD_W  result word, LS word first.
- out_last  out  1  marks the final result word.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE; word counters clear.
  - All outputs 0, including eng_n/eng_m/eng_e, out_data and error.
  - Reset mid-job abandons the job; no done pulse.
- FSM states: IDLE, LOAD, COMPUTE, READ, HOLD.
- IDLE:
  - in_ready=0.
  - start=1 → LOAD; clears load_cnt, rd_cnt and error.
  - start in any other state is ignored.
- LOAD:
  - eng_start=1 and in_ready=1.
  - Transfer when in_valid&in_ready; the triplet registers onto eng_n/m/e and eng_wr=1 the next cycle (1-cycle latency).
  - eng_wr=0 in cycles with no transfer; eng_n/m/e hold their last values.
  - load_cnt increments per transfer.
  - On the transfer with load_cnt==NUM_WORDS-1:
    - next state COMPUTE; in_ready drops the following cycle;
    - the final eng_wr pulse coincides with the first COMPUTE cycle, while eng_start is still 1;
    - eng_start falls one cycle later.
- COMPUTE:
  - in_ready=0.
  - eng_done=1 → READ.
  - eng_done sampled in the same cycle as the final eng_wr is ignored.
- READ:
  - eng_get_result=1 for exactly one cycle, then → HOLD.
  - The next cycle, eng_res is captured into out_data and out_valid=1.
- HOLD:
  - out_valid stays high and out_data stays stable until out_ready=1.
  - out_last=1 when rd_cnt==NUM_WORDS-1.
  - On acceptance:
    - if not the last word: rd_cnt++, → READ;
    - if the last word: done=1 for one cycle, out_valid=0, → IDLE.
  - At most one unaccepted result word exists at any time; no eng_get_result while out_valid=1.
- out_ready held high: one result word per 3 cycles (READ, capture, accept).
- Counters are $clog2(NUM_WORDS) bits wide and never wrap: the LOAD→COMPUTE and HOLD→IDLE exits happen at NUM_WORDS-1.
- busy: set the cycle after start is accepted; clears on the cycle done pulses.

Optional Feature:
- Macro RSA_SEQ_TIMEOUT_EN.
- Defined:
  - a cycle counter runs only in COMPUTE;
  - on reaching TIMEOUT_CYCLES without eng_done: error=1 (sticky until next accepted start), FSM → IDLE, no done pulse, no result words emitted;
  - eng_done arriving later, while IDLE, is ignored.
- Undefined:
  - no counter logic; error is tied to 0;
  - COMPUTE waits indefinitely.

Test Plan:
- NUM_WORDS=4, reset held low 3 cycles → busy=0, in_ready=0, out_valid=0, eng_start=0, error=0. Release; start pulse → busy=1 next cycle, in_ready=1.
- Load n={8E12B6DB,DBF291EB,99A93151,D5E10615}, m={08403477,675152D8,30B302A4,0A76E56A}, e={89F79C82,17AF118B,84F66C41,B77CC5A6} with in_valid gap after word 1 → exactly 4 eng_wr pulses, with gap and word order preserved. eng_start falls one cycle after the last eng_wr.
- Engine model returns {11111111,22222222,33333333,44444444} after eng_done; out_ready=1 throughout → 4 eng_get_result pulses and 4 out words in order. out_last only on 44444444; done pulses once, then busy=0.
- Same job with out_ready low 5 cycles on word 2 → out_data holds 22222222, no further eng_get_result, no word lost or duplicated.
- start asserted during LOAD and COMPUTE → ignored, counts unchanged. Reset driven low mid-LOAD after word 2 → all outputs 0 immediately. A fresh job then completes normally.
- RSA_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=100, engine never asserts eng_done → error=1 at cycle 100 of COMPUTE, busy=0, no out_valid. Next start clears error.
